// File: rtl/uart_byte_tx_if.sv
// Byte-level transmit handshake between the cell-message buffer and the UART serialiser.
// Latency: none (wiring only).
// Backpressure: busy/txdone tell the sender when a new byte may be presented.
interface uart_byte_tx_if;
    logic [7:0] txdata;   // byte to transmit, sampled at frame start
    logic       send;     // level request
    logic       txdone;   // one-cycle pulse after the last stop bit
    logic       busy;     // frame in flight or guard interval active
    logic       tx;       // serial line, idles high

    // Sender side: presents bytes, watches completion and the line.
    modport master (
        output txdata,
        output send,
        input  txdone,
        input  busy,
        input  tx
    );

    // Transmitter side.
    modport slave (
        input  txdata,
        input  send,
        output txdone,
        output busy,
        output tx
    );
endinterface

// File: rtl/uart_byte_tx.sv
// UART 8N1/8N2 byte serialiser: latches a byte on send, shifts it out LSB first, pulses txdone.
// Latency: first start-bit cycle follows the latch edge; txdone one cycle after the last stop bit.
// Backpressure: send is a level request, ignored while busy; a guard interval follows every txdone.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int GUARD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_tx_if.slave  bus
);

    // Baud counter runs 0..CLKS_PER_BIT-1 and is cleared at every bit boundary,
    // so each bit is exactly CLKS_PER_BIT cycles and no error accumulates.
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST  = 3'd7;
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4,
        S_GUARD = 3'd5
    } state_t;

    state_t          state_q,  state_d;
    logic [BW-1:0]   baud_q,   baud_d;
    logic [2:0]      bit_q,    bit_d;     // data bit index in DATA, stop bit index in STOP
    logic [GW-1:0]   guard_q,  guard_d;
    logic [7:0]      shift_q,  shift_d;
    logic            tx_q,     tx_d;
    logic            txdone_q, txdone_d;
    logic            busy_q,   busy_d;

    logic            bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state logic; every output is computed one cycle ahead so the registered
    // value lines up with the state it belongs to.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        guard_d  = guard_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        txdone_d = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                if (bus.send) begin
                    shift_d = bus.txdata;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        // Next bit is what shift[0] becomes after this shift.
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d    = '0;
                        state_d  = S_DONE;
                        txdone_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            S_DONE: begin
                // txdone is high during this single cycle; drop it on the way out.
                tx_d    = 1'b1;
                guard_d = '0;
                state_d = S_GUARD;
            end

            S_GUARD: begin
                // send is deliberately ignored here so a sender that updates txdata
                // in the cycle after txdone is sampled with its fresh byte.
                tx_d = 1'b1;
                if (guard_q == GUARD_LAST) begin
                    guard_d = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                guard_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            guard_q  <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            txdone_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            guard_q  <= guard_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            txdone_q <= txdone_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.tx     = tx_q;
    assign bus.txdone = txdone_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: line waveform, txdone timing, guard gap, abort and 2-stop variant.
// Latency: checks every line cycle against a per-bit expectation queue.
// Backpressure: exercises held send, mid-frame send drop and reset mid-frame.
module tb_uart_byte_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] txdata;
    logic       send;
    logic [7:0] b_txdata;
    logic       b_send;
    bit         sel;

    int total = 0;
    int bad   = 0;

    // Scoreboard: one entry per serial bit (start, 8 data LSB first, stop bits).
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_byte_tx_if a_if ();
    uart_byte_tx_if b_if ();

    assign a_if.txdata = txdata;
    assign a_if.send   = send;
    assign b_if.txdata = b_txdata;
    assign b_if.send   = b_send;

    uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .GUARD_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .GUARD_CYCLES(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    logic m_tx, m_txdone, m_busy;
    assign m_tx     = sel ? b_if.tx     : a_if.tx;
    assign m_txdone = sel ? b_if.txdone : a_if.txdone;
    assign m_busy   = sel ? b_if.busy   : a_if.busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    // Advance until the line goes low, bounded.
    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (m_tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_start_seen"}, {31'd0, m_tx}, 32'd0);
    endtask

    // Called on the first low cycle; checks every cycle of the frame, then the txdone cycle.
    task automatic check_frame(input string name, input int nbits, input bit disturb);
        logic e;
        logic ok;
        for (int i = 0; i < nbits; i++) begin
            e  = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            ok = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (!(i == 0 && c == 0)) @(negedge clk);
                if (disturb && i == 4 && c == 0) begin
                    txdata = ~txdata;
                    send   = 1'b0;
                end
                if (m_tx !== e || m_txdone !== 1'b0 || m_busy !== 1'b1) ok = 1'b0;
            end
            chk($sformatf("%s_bit%0d_line_ok", name, i), {31'd0, ok}, 32'd1);
        end
        @(negedge clk);
        chk({name, "_txdone"}, {31'd0, m_txdone}, 32'd1);
    endtask

    initial begin
        int viol;
        int gap;
        int pulses;
        int lows;

        rst      = 1'b1;
        send     = 1'b0;
        txdata   = 8'h00;
        b_send   = 1'b0;
        b_txdata = 8'h00;
        sel      = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_tx",     {31'd0, m_tx},     32'd1);
        chk("rst_busy",   {31'd0, m_busy},   32'd0);
        chk("rst_txdone", {31'd0, m_txdone}, 32'd0);
        rst  = 1'b0;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_txdone !== 1'b0) viol++;
        end
        chk("idle_violations", viol, 0);

        // One-shot 8'hA5
        txdata = 8'hA5;
        send   = 1'b1;
        push_frame(8'hA5, 1);
        @(negedge clk);
        send = 1'b0;
        wait_start("a5");
        check_frame("a5", 10, 1'b0);
        @(negedge clk);
        chk("a5_txdone_drop", {31'd0, m_txdone}, 32'd0);
        chk("a5_guard_busy",  {31'd0, m_busy},   32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("a5_idle_busy",   {31'd0, m_busy},   32'd0);

        // Held send, buffer-style update after txdone
        repeat (3) @(negedge clk);
        txdata = 8'h30;
        send   = 1'b1;
        push_frame(8'h30, 1);
        @(negedge clk);
        wait_start("h30");
        check_frame("h30", 10, 1'b0);
        @(negedge clk);
        txdata = 8'hC0;
        push_frame(8'hC0, 1);
        gap = 0;
        while (m_tx === 1'b1 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        chk("guard_gap", gap, 3);
        check_frame("hC0", 10, 1'b0);
        send = 1'b0;
        repeat (6) @(negedge clk);
        chk("hC0_idle_busy", {31'd0, m_busy}, 32'd0);

        // Mid-frame txdata toggle and send drop
        txdata = 8'h0F;
        send   = 1'b1;
        push_frame(8'h0F, 1);
        @(negedge clk);
        wait_start("h0F");
        check_frame("h0F", 10, 1'b1);
        pulses = 0;
        lows   = 0;
        repeat (30) begin
            @(negedge clk);
            if (m_txdone === 1'b1) pulses++;
            if (m_tx !== 1'b1) lows++;
        end
        chk("h0F_extra_txdone", pulses, 0);
        chk("h0F_extra_low",    lows,   0);
        chk("h0F_idle_busy",    {31'd0, m_busy}, 32'd0);

        // Reset during data bit 4 of 8'hFF with send held
        txdata = 8'hFF;
        send   = 1'b1;
        push_frame(8'hFF, 1);
        @(negedge clk);
        chk("ff_first_low", {31'd0, m_tx}, 32'd0);
        pulses = 0;
        repeat (21) begin
            @(negedge clk);
            if (m_txdone === 1'b1) pulses++;
        end
        chk("ff_bit4_level", {31'd0, m_tx}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx",     {31'd0, m_tx},     32'd1);
        chk("abort_busy",   {31'd0, m_busy},   32'd0);
        chk("abort_txdone", {31'd0, m_txdone}, 32'd0);
        chk("abort_no_txdone_before", pulses, 0);
        rst = 1'b0;
        exp_q.delete();
        push_frame(8'hFF, 1);
        @(negedge clk);
        chk("restart_first_edge", {31'd0, m_tx}, 32'd0);
        check_frame("ff_restart", 10, 1'b0);
        send = 1'b0;
        repeat (6) @(negedge clk);

        // Two stop bits, 8'h00
        sel      = 1'b1;
        b_txdata = 8'h00;
        b_send   = 1'b1;
        push_frame(8'h00, 2);
        @(negedge clk);
        b_send = 1'b0;
        wait_start("stop2");
        check_frame("stop2", 11, 1'b0);
        @(negedge clk);
        chk("stop2_txdone_drop", {31'd0, m_txdone}, 32'd0);

        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
